// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: EX/MEM request to req/ack data bus,
// load formatting, pipeline stall, misalign/illegal/timeout fault.
module mem_stage_lsu #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mr_in,
  input  logic        mw_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TO_EN ? TIMEOUT - 1 : 0);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             to_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;

  logic        access;
  logic        bad;
  logic        go;
  logic        is_h;
  logic        is_w;
  logic        ill_ld;
  logic        ill_st;
  logic        to_hit;
  logic [31:0] st_data;
  logic [3:0]  st_strb;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_fmt;

  assign access = mr_in | mw_in;
  assign is_h   = funct3_in[1:0] == 2'd1;
  assign is_w   = funct3_in[1:0] == 2'd2;
  assign ill_ld = mr_in & ((funct3_in[1:0] == 2'd3)
                | (funct3_in == 3'd6));
  assign ill_st = mw_in & (funct3_in[2]
                | (funct3_in[1:0] == 2'd3));
  assign bad    = (mr_in & mw_in) | ill_ld | ill_st
                | (is_h & addr_in[0])
                | (is_w & (|addr_in[1:0]));
  assign go     = access & ~bad;
  assign to_hit = TO_EN && (cnt == TO_LAST);

  always_comb begin
    st_data = wdata_in;
    st_strb = 4'b1111;
    case (funct3_in[1:0])
      2'd0: begin
        st_data = {4{wdata_in[7:0]}};
        st_strb = 4'b0001 << addr_in[1:0];
      end
      2'd1: begin
        st_data = {2{wdata_in[15:0]}};
        st_strb = addr_in[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Lane extraction uses the offset latched at issue, not addr_in.
  always_comb begin
    ld_b   = 8'(mem_rdata >> {off_q, 3'b000});
    ld_h   = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_fmt = mem_rdata;
    case (f3_q[1:0])
      2'd0: ld_fmt = {{24{ld_b[7] & ~f3_q[2]}}, ld_b};
      2'd1: ld_fmt = {{16{ld_h[15] & ~f3_q[2]}}, ld_h};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    fault    = 1'b0;
    case (state)
      S_IDLE: begin
        stall = go;
        fault = access & bad;
        if (go) state_nx = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (mem_ack || to_hit) state_nx = S_DONE;
      end
      S_DONE: begin
        fault    = to_q;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (!reset) begin
      stall = 1'b0;
      fault = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      cnt        <= '0;
      to_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            mem_req   <= 1'b1;
            mem_we    <= mw_in;
            mem_addr  <= {addr_in[31:2], 2'b00};
            mem_wdata <= st_data;
            mem_wstrb <= mw_in ? st_strb : 4'b0000;
            f3_q      <= funct3_in;
            off_q     <= addr_in[1:0];
            cnt       <= '0;
          end
        end
        S_WAIT: begin
          // Ack takes priority over a timeout on the same edge.
          if (mem_ack || to_hit) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
          end
          if (mem_ack) begin
            if (!mem_we) begin
              load_data  <= ld_fmt;
              load_valid <= 1'b1;
            end
          end else if (to_hit) begin
            load_data <= '0;
            to_q      <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          load_valid <= 1'b0;
          to_q       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed table, random
// traffic against a reference model, reset-in-flight sequence.
module tb_mem_stage_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mr_in, mw_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in, wdata_in;
  logic        stall, load_valid, fault;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  mem_stage_lsu #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .mr_in(mr_in), .mw_in(mw_in),
    .funct3_in(funct3_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .stall(stall),
    .load_data(load_data), .load_valid(load_valid),
    .fault(fault), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          nw;
    logic        bad;
    logic [31:0] ea;
    logic [31:0] ewd;
    logic [3:0]  es;
    logic [31:0] eld;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic m_bad(logic mr, logic mw,
                                 logic [2:0] f3,
                                 logic [31:0] a);
    int sz;
    int f;
    f = int'(f3);
    if (!mr && !mw) return 1'b0;
    if (mr && mw) return 1'b1;
    if (mr && !(f inside {0, 1, 2, 4, 5})) return 1'b1;
    if (mw && !(f inside {0, 1, 2})) return 1'b1;
    sz = 1 << (f % 4);
    return (int'(a % 4) % sz) != 0;
  endfunction

  function automatic logic [31:0] m_ld(logic [2:0] f3,
                                       logic [31:0] a,
                                       logic [31:0] rd);
    longint v;
    int off;
    off = int'(a % 4);
    case (int'(f3))
      0, 4: begin
        v = longint'((rd >> (8 * off)) & 32'hFF);
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      1, 5: begin
        v = longint'((rd >> (8 * off)) & 32'hFFFF);
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(rd);
    endcase
    return 32'(v);
  endfunction

  task automatic m_st(input logic [2:0] f3,
                      input logic [31:0] a, wd,
                      output logic [31:0] ewd,
                      output logic [3:0] es);
    int off;
    off = int'(a % 4);
    case (int'(f3))
      0: begin
        ewd = (wd & 32'hFF) * 32'h01010101;
        es  = 4'(1 << off);
      end
      1: begin
        ewd = (wd & 32'hFFFF) * 32'h00010001;
        es  = 4'(3 << off);
      end
      default: begin
        ewd = wd;
        es  = 4'hF;
      end
    endcase
  endtask

  task automatic clr_in();
    mr_in = 1'b0; mw_in = 1'b0; funct3_in = '0;
    addr_in = '0; wdata_in = '0;
  endtask

  task automatic junk_in();
    mr_in     = 1'($urandom_range(0, 1));
    mw_in     = 1'($urandom_range(0, 1));
    funct3_in = 3'($urandom_range(0, 7));
    addr_in   = $urandom;
    wdata_in  = $urandom;
  endtask

  task automatic xact(input vec_t v);
    logic to;
    int last;
    @(posedge clk); #1;
    mr_in = v.mr; mw_in = v.mw; funct3_in = v.f3;
    addr_in = v.a; wdata_in = v.wd; mem_ack = 1'b0;
    @(negedge clk);
    chk("dec_stall", 32'(stall), 32'(!v.bad && (v.mr || v.mw)));
    chk("dec_fault", 32'(fault), 32'(v.bad));
    chk("dec_req", 32'(mem_req), 32'd0);
    if (v.bad || (!v.mr && !v.mw)) begin
      @(posedge clk); #1 clr_in();
      @(negedge clk);
      chk("nb_req", 32'(mem_req), 32'd0);
      chk("nb_fault", 32'(fault), 32'd0);
    end else begin
      to   = !(v.nw >= 1 && v.nw <= TO);
      last = to ? TO : v.nw;
      for (int w = 1; w <= last; w++) begin
        @(posedge clk); #1;
        junk_in();
        mem_ack   = (w == v.nw);
        mem_rdata = (w == v.nw) ? v.rd : $urandom;
        @(negedge clk);
        chk("w_req", 32'(mem_req), 32'd1);
        chk("w_stall", 32'(stall), 32'd1);
        chk("w_we", 32'(mem_we), 32'(v.mw));
        chk("w_addr", mem_addr, v.ea);
        chk("w_strb", 32'(mem_wstrb), 32'(v.es));
        if (v.mw) chk("w_wdata", mem_wdata, v.ewd);
        chk("w_fault", 32'(fault), 32'd0);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = $urandom;
      @(negedge clk);
      chk("d_stall", 32'(stall), 32'd0);
      chk("d_req", 32'(mem_req), 32'd0);
      chk("d_fault", 32'(fault), 32'(to));
      chk("d_lv", 32'(load_valid), 32'(v.mr && !to));
      if (v.mr) chk("d_ld", load_data, to ? 32'd0 : v.eld);
      @(posedge clk); #1 clr_in();
      @(negedge clk);
      chk("p_lv", 32'(load_valid), 32'd0);
      chk("p_fault", 32'(fault), 32'd0);
      chk("p_stall", 32'(stall), 32'd0);
      chk("p_req", 32'(mem_req), 32'd0);
    end
  endtask

  initial begin
    vec_t v;
    logic [31:0] a;
    int r;

    tbl[0]  = '{1, 0, 2, 32'h1000, 0, 32'hDEADBEEF, 2,
                0, 32'h1000, 0, 4'b0000, 32'hDEADBEEF};
    tbl[1]  = '{1, 0, 0, 32'h1003, 0, 32'h80FF0011, 1,
                0, 32'h1000, 0, 4'b0000, 32'hFFFFFF80};
    tbl[2]  = '{1, 0, 4, 32'h1003, 0, 32'h80FF0011, 1,
                0, 32'h1000, 0, 4'b0000, 32'h00000080};
    tbl[3]  = '{1, 0, 5, 32'h1002, 0, 32'h80FF0011, 1,
                0, 32'h1000, 0, 4'b0000, 32'h000080FF};
    tbl[4]  = '{1, 0, 1, 32'h1002, 0, 32'h80FF0011, 3,
                0, 32'h1000, 0, 4'b0000, 32'hFFFF80FF};
    tbl[5]  = '{0, 1, 0, 32'h2001, 32'hAB, 0, 1,
                0, 32'h2000, 32'hABABABAB, 4'b0010, 0};
    tbl[6]  = '{0, 1, 1, 32'h2002, 32'h1234, 0, 2,
                0, 32'h2000, 32'h12341234, 4'b1100, 0};
    tbl[7]  = '{0, 1, 2, 32'h2004, 32'hCAFEF00D, 0, 3,
                0, 32'h2004, 32'hCAFEF00D, 4'b1111, 0};
    tbl[8]  = '{1, 0, 1, 32'h3001, 0, 0, 1,
                1, 0, 0, 4'b0000, 0};
    tbl[9]  = '{1, 0, 2, 32'h3002, 0, 0, 1,
                1, 0, 0, 4'b0000, 0};
    tbl[10] = '{1, 1, 2, 32'h3000, 0, 0, 1,
                1, 0, 0, 4'b0000, 0};
    tbl[11] = '{1, 0, 2, 32'h4000, 0, 32'h55AA55AA, 0,
                0, 32'h4000, 0, 4'b0000, 0};
    tbl[12] = '{1, 0, 2, 32'h4004, 0, 32'h12345678, 4,
                0, 32'h4004, 0, 4'b0000, 32'h12345678};
    tbl[13] = '{0, 1, 2, 32'h4008, 32'h1, 0, 0,
                0, 32'h4008, 32'h1, 4'b1111, 0};
    tbl[14] = '{0, 1, 3, 32'h5000, 32'h77, 0, 1,
                1, 0, 0, 4'b0000, 0};
    tbl[15] = '{1, 0, 6, 32'h5000, 0, 0, 1,
                1, 0, 0, 4'b0000, 0};
    tbl[16] = '{0, 0, 2, 32'h6000, 0, 0, 1,
                0, 0, 0, 4'b0000, 0};

    reset = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    mr_in = 1'b1; mw_in = 1'b1; funct3_in = 3'd2;
    addr_in = 32'h3; wdata_in = '0;
    #12;
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    mw_in = 1'b0; addr_in = 32'h100;
    #1;
    chk("rst_stall2", 32'(stall), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_bus", mem_addr | mem_wdata | 32'(mem_wstrb), 32'd0);
    chk("rst_ld", load_data, 32'd0);
    chk("rst_lv", 32'(load_valid), 32'd0);
    @(negedge clk);
    clr_in();
    reset = 1'b1;

    for (int i = 0; i < 17; i++) xact(tbl[i]);

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      v.mr = (r < 4) || (r == 8);
      v.mw = (r >= 4 && r < 9);
      v.f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0 && v.f3 != 3'd3)
        v.f3 = v.mw ? 3'($urandom_range(0, 2)) : v.f3;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      v.a   = a;
      v.wd  = $urandom;
      v.rd  = $urandom;
      v.nw  = $urandom_range(0, 6);
      v.bad = m_bad(v.mr, v.mw, v.f3, v.a);
      v.ea  = v.a - (v.a % 4);
      v.eld = m_ld(v.f3, v.a, v.rd);
      v.ewd = '0;
      v.es  = '0;
      if (v.mw) m_st(v.f3, v.a, v.wd, v.ewd, v.es);
      xact(v);
    end

    @(posedge clk); #1;
    mr_in = 1'b1; funct3_in = 3'd2; addr_in = 32'h7000;
    @(posedge clk); #1;
    junk_in();
    @(negedge clk);
    chk("mid_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_req", 32'(mem_req), 32'd0);
    chk("ar_stall", 32'(stall), 32'd0);
    chk("ar_fault", 32'(fault), 32'd0);
    chk("ar_bus", mem_addr | mem_wdata | 32'(mem_wstrb)
        | 32'(mem_we), 32'd0);
    chk("ar_ld", load_data | 32'(load_valid), 32'd0);
    @(negedge clk);
    clr_in();
    reset = 1'b1;
    #1;
    chk("ar_idle", 32'(stall), 32'd0);
    xact(tbl[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
